// File: rtl/gpr_bus_sequencer.sv
// GPR bus sequencer: registered per-register assert/load strobes for MainBus, LHSBus, RHSBus, plus MainBus debug arbitration.
// Latency: one cycle. A request sampled at edge N drives its strobes during cycle N+1.
// Backpressure: wb_ready drops for one cycle after sustained debug starvation; a stall freezes the operand strobes.
module gpr_bus_sequencer #(
   parameter int NUM_REGS   = 4,
   parameter int SEL_W      = 2,
   parameter int STARVE_MAX = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                op_valid,
   input  logic                lhs_en,
   input  logic [SEL_W-1:0]    lhs_sel,
   input  logic                rhs_en,
   input  logic [SEL_W-1:0]    rhs_sel,
   input  logic                wb_valid,
   output logic                wb_ready,
   input  logic [SEL_W-1:0]    wb_dst,
   input  logic                wb_from_reg,
   input  logic [SEL_W-1:0]    wb_src,
   output logic                wb_ext_oe,
   input  logic                dbg_req,
   input  logic                dbg_write,
   input  logic [SEL_W-1:0]    dbg_sel,
   output logic                dbg_ack,
   output logic                dbg_oe,
   output logic [NUM_REGS-1:0] a_main_n,
   output logic [NUM_REGS-1:0] load_n,
   output logic [NUM_REGS-1:0] a_lhs_n,
   output logic [NUM_REGS-1:0] a_rhs_n,
   output logic                bus_conflict
);

   typedef enum logic [1:0] {
      DBG_IDLE    = 2'd0,
      DBG_GRANT   = 2'd1,
      DBG_RECOVER = 2'd2
   } dbg_state_t;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   dbg_state_t          state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                dbg_grant;
   logic                wb_accept;
   logic                ready_d;
   logic                ext_oe_d;
   logic                dbg_oe_d;
   logic                ack_d;
   logic [NUM_REGS-1:0] main_d;
   logic [NUM_REGS-1:0] load_d;
   logic [NUM_REGS-1:0] lhs_d;
   logic [NUM_REGS-1:0] rhs_d;
   logic                conflict_now;

   // Active-low one-hot strobe for a register select; out-of-range selects strobe nothing.
   function automatic logic [NUM_REGS-1:0] strobe_n(input logic [SEL_W-1:0] sel, input logic en);
      logic [NUM_REGS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (int'(sel) == i)) begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   // Debug FSM next state, starvation counter, MainBus arbitration and next strobe values.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      main_d   = '1;
      load_d   = '1;
      ext_oe_d = 1'b0;
      dbg_oe_d = 1'b0;
      ack_d    = 1'b0;

      // wb wins unless wb_ready is low, which is the forced-grant cycle.
      dbg_grant = (state_q == DBG_IDLE) && dbg_req && (!wb_valid || !wb_ready);
      wb_accept = wb_valid && wb_ready && !dbg_grant;

      case (state_q)
         DBG_IDLE:    if (dbg_grant) state_d = DBG_GRANT;
         DBG_GRANT:   state_d = DBG_RECOVER;
         DBG_RECOVER: state_d = DBG_IDLE;
         default:     state_d = DBG_IDLE;
      endcase

      // Counter only advances while waiting in IDLE; it holds through GRANT/RECOVER.
      if (!dbg_req || dbg_grant) begin
         cnt_d = '0;
      end else if ((state_q == DBG_IDLE) && (cnt_q < STARVE_LIM)) begin
         cnt_d = cnt_q + 8'd1;
      end
      ready_d = (cnt_d != STARVE_LIM);

      if (dbg_grant) begin
         ack_d = 1'b1;
         if (dbg_write) begin
            dbg_oe_d = 1'b1;
            load_d   = strobe_n(dbg_sel, 1'b1);
         end else begin
            main_d   = strobe_n(dbg_sel, 1'b1);
         end
      end else if (wb_accept) begin
         if (wb_from_reg) begin
            // Copying a register onto itself is accepted but needs no bus activity.
            if (wb_src != wb_dst) begin
               main_d = strobe_n(wb_src, 1'b1);
               load_d = strobe_n(wb_dst, 1'b1);
            end
         end else begin
            ext_oe_d = 1'b1;
            load_d   = strobe_n(wb_dst, 1'b1);
         end
      end

      if (stall) begin
         lhs_d = a_lhs_n;
         rhs_d = a_rhs_n;
      end else if (op_valid) begin
         lhs_d = strobe_n(lhs_sel, lhs_en);
         rhs_d = strobe_n(rhs_sel, rhs_en);
      end else begin
         lhs_d = '1;
         rhs_d = '1;
      end
   end

   // Flag more than one MainBus driver in the current cycle.
   always_comb begin
      int drivers;
      drivers      = $countones(~a_main_n) + int'(wb_ext_oe) + int'(dbg_oe);
      conflict_now = (drivers > 1);
   end

   // State and output registers; reset aborts any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= DBG_IDLE;
         cnt_q        <= '0;
         wb_ready     <= 1'b1;
         wb_ext_oe    <= 1'b0;
         dbg_oe       <= 1'b0;
         dbg_ack      <= 1'b0;
         a_main_n     <= '1;
         load_n       <= '1;
         a_lhs_n      <= '1;
         a_rhs_n      <= '1;
         bus_conflict <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wb_ready     <= ready_d;
         wb_ext_oe    <= ext_oe_d;
         dbg_oe       <= dbg_oe_d;
         dbg_ack      <= ack_d;
         a_main_n     <= main_d;
         load_n       <= load_d;
         a_lhs_n      <= lhs_d;
         a_rhs_n      <= rhs_d;
         bus_conflict <= bus_conflict | conflict_now;
      end
   end

endmodule

// File: tb/tb_gpr_bus_sequencer.sv
// Bench for gpr_bus_sequencer: directed scenarios then random traffic against a cycle-level reference model.
// Expected outputs are queued per clock edge and popped by an independent monitor.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_gpr_bus_sequencer;

   localparam int NUM_REGS   = 4;
   localparam int SEL_W      = 2;
   localparam int STARVE_MAX = 7;

   logic                clk;
   logic                rst;
   logic                stall;
   logic                op_valid;
   logic                lhs_en;
   logic [SEL_W-1:0]    lhs_sel;
   logic                rhs_en;
   logic [SEL_W-1:0]    rhs_sel;
   logic                wb_valid;
   logic                wb_ready;
   logic [SEL_W-1:0]    wb_dst;
   logic                wb_from_reg;
   logic [SEL_W-1:0]    wb_src;
   logic                wb_ext_oe;
   logic                dbg_req;
   logic                dbg_write;
   logic [SEL_W-1:0]    dbg_sel;
   logic                dbg_ack;
   logic                dbg_oe;
   logic [NUM_REGS-1:0] a_main_n;
   logic [NUM_REGS-1:0] load_n;
   logic [NUM_REGS-1:0] a_lhs_n;
   logic [NUM_REGS-1:0] a_rhs_n;
   logic                bus_conflict;

   gpr_bus_sequencer #(
      .NUM_REGS  (NUM_REGS),
      .SEL_W     (SEL_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .op_valid    (op_valid),
      .lhs_en      (lhs_en),
      .lhs_sel     (lhs_sel),
      .rhs_en      (rhs_en),
      .rhs_sel     (rhs_sel),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_dst      (wb_dst),
      .wb_from_reg (wb_from_reg),
      .wb_src      (wb_src),
      .wb_ext_oe   (wb_ext_oe),
      .dbg_req     (dbg_req),
      .dbg_write   (dbg_write),
      .dbg_sel     (dbg_sel),
      .dbg_ack     (dbg_ack),
      .dbg_oe      (dbg_oe),
      .a_main_n    (a_main_n),
      .load_n      (load_n),
      .a_lhs_n     (a_lhs_n),
      .a_rhs_n     (a_rhs_n),
      .bus_conflict(bus_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_REGS-1:0] main_n;
      logic [NUM_REGS-1:0] load_n;
      logic [NUM_REGS-1:0] lhs_n;
      logic [NUM_REGS-1:0] rhs_n;
      logic                ready;
      logic                ext_oe;
      logic                ack;
      logic                oe;
      logic                conflict;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state, kept as plain counters.
   logic [NUM_REGS-1:0] m_lhs;
   logic [NUM_REGS-1:0] m_rhs;
   bit                  m_ready;
   int                  m_denied;   // consecutive denied debug cycles
   int                  m_cool;     // cycles left before debug may be granted again

   function automatic logic [NUM_REGS-1:0] low_at(input int sel);
      logic [NUM_REGS-1:0] v;
      v = '1;
      if (sel < NUM_REGS) v[sel] = 1'b0;
      return v;
   endfunction

   // Predict the outputs visible after the current rising edge from the inputs it samples.
   task automatic model_step();
      exp_t e;
      bit   grant;
      bit   accept;
      e.main_n   = '1;
      e.load_n   = '1;
      e.ext_oe   = 1'b0;
      e.oe       = 1'b0;
      e.ack      = 1'b0;
      e.conflict = 1'b0;
      if (rst) begin
         m_lhs    = '1;
         m_rhs    = '1;
         m_ready  = 1'b1;
         m_denied = 0;
         m_cool   = 0;
      end else begin
         grant  = (m_cool == 0) && dbg_req && (!wb_valid || !m_ready);
         accept = wb_valid && m_ready && !grant;
         e.ack  = grant;
         if (grant) begin
            if (dbg_write) begin
               e.oe     = 1'b1;
               e.load_n = low_at(int'(dbg_sel));
            end else begin
               e.main_n = low_at(int'(dbg_sel));
            end
         end
         if (accept) begin
            if (!wb_from_reg) begin
               e.ext_oe = 1'b1;
               e.load_n = low_at(int'(wb_dst));
            end else if (wb_src != wb_dst) begin
               e.main_n = low_at(int'(wb_src));
               e.load_n = low_at(int'(wb_dst));
            end
         end
         if (!stall) begin
            m_lhs = (op_valid && lhs_en) ? low_at(int'(lhs_sel)) : '1;
            m_rhs = (op_valid && rhs_en) ? low_at(int'(rhs_sel)) : '1;
         end
         if (!dbg_req || grant)                         m_denied = 0;
         else if (m_cool == 0 && m_denied < STARVE_MAX) m_denied = m_denied + 1;
         m_ready = (m_denied != STARVE_MAX);
         if (grant)           m_cool = 2;
         else if (m_cool > 0) m_cool = m_cool - 1;
      end
      e.lhs_n = m_lhs;
      e.rhs_n = m_rhs;
      e.ready = m_ready;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_idle();
      stall       = 1'b0;
      op_valid    = 1'b0;
      lhs_en      = 1'b0;
      lhs_sel     = '0;
      rhs_en      = 1'b0;
      rhs_sel     = '0;
      wb_valid    = 1'b0;
      wb_dst      = '0;
      wb_from_reg = 1'b0;
      wb_src      = '0;
      dbg_req     = 1'b0;
      dbg_write   = 1'b0;
      dbg_sel     = '0;
   endtask

   // Monitor: every falling edge with a pending prediction is one compared vector.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.main_n   = a_main_n;
            a.load_n   = load_n;
            a.lhs_n    = a_lhs_n;
            a.rhs_n    = a_rhs_n;
            a.ready    = wb_ready;
            a.ext_oe   = wb_ext_oe;
            a.ack      = dbg_ack;
            a.oe       = dbg_oe;
            a.conflict = bus_conflict;
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL vec%0d t=%0t got main=%b load=%b lhs=%b rhs=%b rdy=%b ext=%b ack=%b oe=%b cf=%b want main=%b load=%b lhs=%b rhs=%b rdy=%b ext=%b ack=%b oe=%b cf=%b",
                        vectors, $time, a.main_n, a.load_n, a.lhs_n, a.rhs_n, a.ready, a.ext_oe, a.ack, a.oe, a.conflict,
                        e.main_n, e.load_n, e.lhs_n, e.rhs_n, e.ready, e.ext_oe, e.ack, e.oe, e.conflict);
            end
         end
      end
   end

   initial begin
      set_idle();
      rst = 1'b1;
      #1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Operand fetch on the same register for both buses, then hold through a stall.
      op_valid = 1'b1; lhs_en = 1'b1; lhs_sel = 2'd1; rhs_en = 1'b1; rhs_sel = 2'd1;
      tick();
      op_valid = 1'b0; stall = 1'b1;
      repeat (3) tick();
      stall = 1'b0;
      tick();

      // Write-back: register copy, self-copy no-op, external source.
      wb_valid = 1'b1; wb_from_reg = 1'b1; wb_src = 2'd2; wb_dst = 2'd0;
      tick();
      wb_src = 2'd3; wb_dst = 2'd3;
      tick();
      wb_from_reg = 1'b0; wb_dst = 2'd3;
      tick();
      wb_valid = 1'b0;
      tick();

      // Debug read held through GRANT and RECOVER.
      dbg_req = 1'b1; dbg_write = 1'b0; dbg_sel = 2'd2;
      repeat (3) tick();
      dbg_req = 1'b0;
      repeat (2) tick();

      // Starvation: continuous write-back traffic against a debug write.
      wb_valid = 1'b1; wb_from_reg = 1'b1; wb_src = 2'd0; wb_dst = 2'd2;
      dbg_req = 1'b1; dbg_write = 1'b1; dbg_sel = 2'd1;
      repeat (10) tick();
      dbg_req = 1'b0;
      repeat (3) tick();
      set_idle();
      tick();

      // Reset on the cycle a write-back is accepted, then confirm debug grants immediately.
      wb_valid = 1'b1; wb_from_reg = 1'b1; wb_src = 2'd1; wb_dst = 2'd3; rst = 1'b1;
      tick();
      rst = 1'b0; set_idle();
      tick();
      dbg_req = 1'b1; dbg_sel = 2'd0;
      tick();
      dbg_req = 1'b0;
      repeat (3) tick();

      // Random traffic with sticky debug requests to reach starvation often.
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 299) == 0);
         stall       = ($urandom_range(0, 3) == 0);
         op_valid    = $urandom_range(0, 1) == 1;
         lhs_en      = $urandom_range(0, 3) != 0;
         lhs_sel     = SEL_W'($urandom);
         rhs_en      = $urandom_range(0, 3) != 0;
         rhs_sel     = SEL_W'($urandom);
         wb_valid    = $urandom_range(0, 9) < 8;
         wb_from_reg = $urandom_range(0, 1) == 1;
         wb_src      = SEL_W'($urandom);
         wb_dst      = SEL_W'($urandom);
         if ($urandom_range(0, 15) == 0) dbg_req = ~dbg_req;
         if ($urandom_range(0, 7) == 0) begin
            dbg_write = $urandom_range(0, 1) == 1;
            dbg_sel   = SEL_W'($urandom);
         end
         tick();
      end
      rst = 1'b0;
      set_idle();
      repeat (3) tick();

      @(negedge clk);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
